// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction-fetch controller. It owns the PC, runs the imem
//            handshake and holds fetched words in a stallable IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [15:0] RST_PC = 16'h0000,
    parameter logic [3:0]  HLT_OP = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    input  logic        if_stall,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pcs,
    input  logic        br_valid,
    input  logic        br_src,
    input  logic [2:0]  br_cond,
    input  logic [15:0] br_imm_tgt,
    input  logic [15:0] br_reg_tgt,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        flag_v,
    output logic        flush,
    output logic        halted
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_HALT  = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_drain_addr;
    logic        r_if_valid;
    logic [15:0] r_if_instr;
    logic [15:0] r_if_pc;
    logic [15:0] r_if_pcs;
    logic        r_flush;

    logic        w_cond_true;
    logic        w_taken;
    logic        w_req;
    logic        w_done;
    logic [15:0] w_target;

    // Code 111 never looks at the flags, so unknown flag values cannot leak in.
    always_comb begin
        w_cond_true = 1'b0;
        case (br_cond)
            3'b000:  w_cond_true = ~flag_z;
            3'b001:  w_cond_true = flag_z;
            3'b010:  w_cond_true = ~flag_z & ~flag_n;
            3'b011:  w_cond_true = flag_n;
            3'b100:  w_cond_true = flag_z | (~flag_z & ~flag_n);
            3'b101:  w_cond_true = flag_z | flag_n;
            3'b110:  w_cond_true = flag_v;
            default: w_cond_true = 1'b1;
        endcase
    end

    assign w_taken  = br_valid & w_cond_true;
    assign w_target = br_src ? br_reg_tgt : br_imm_tgt;
    assign w_req    = ((r_state == c_ST_FETCH) && !(r_if_valid && if_stall)) ||
                      (r_state == c_ST_DRAIN);
    assign w_done   = w_req & imem_ready;

    always_comb begin
        imem_addr = 16'h0000;
        case (r_state)
            c_ST_FETCH: imem_addr = r_pc;
            c_ST_DRAIN: imem_addr = r_drain_addr;
            c_ST_HALT:  imem_addr = r_pc;
            default:    imem_addr = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_pc         <= RST_PC;
            r_drain_addr <= 16'h0000;
            r_if_valid   <= 1'b0;
            r_if_instr   <= 16'h0000;
            r_if_pc      <= 16'h0000;
            r_if_pcs     <= 16'h0000;
            r_flush      <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            // Decode consumes the live word whenever it is not stalling.
            if (!if_stall) begin
                r_if_valid <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    r_state <= c_ST_FETCH;
                end
                c_ST_FETCH: begin
                    if (w_taken) begin
                        r_pc       <= w_target;
                        r_flush    <= 1'b1;
                        r_if_valid <= 1'b0;
                        if (w_req && !imem_ready) begin
                            r_state      <= c_ST_DRAIN;
                            r_drain_addr <= r_pc;
                        end
                    end else if (w_done) begin
                        r_if_valid <= 1'b1;
                        r_if_instr <= imem_data;
                        r_if_pc    <= r_pc;
                        r_if_pcs   <= r_pc + 16'd2;
                        if (imem_data[15:12] == HLT_OP) begin
                            r_state <= c_ST_HALT;
                        end else begin
                            r_pc <= r_pc + 16'd2;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    // The stale response is swallowed; only the redirect matters.
                    if (w_taken) begin
                        r_pc       <= w_target;
                        r_flush    <= 1'b1;
                        r_if_valid <= 1'b0;
                    end
                    if (imem_ready) begin
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_HALT: begin
                    if (w_taken) begin
                        r_pc       <= w_target;
                        r_flush    <= 1'b1;
                        r_if_valid <= 1'b0;
                        r_state    <= c_ST_FETCH;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req = w_req;
    assign if_valid = r_if_valid;
    assign if_instr = r_if_instr;
    assign if_pc    = r_if_pc;
    assign if_pcs   = r_if_pcs;
    assign flush    = r_flush;
    assign halted   = (r_state == c_ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed bench for fetch_ctrl: hand sequences plus a branch
//            condition vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        if_stall;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pcs;
    logic        br_valid;
    logic        br_src;
    logic [2:0]  br_cond;
    logic [15:0] br_imm_tgt;
    logic [15:0] br_reg_tgt;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;
    logic        flush;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       v;
        logic       src;
        logic [2:0] cond;
        logic       z;
        logic       n;
        logic       vf;
        logic       exp_taken;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    // Memory image: word at 0x0010 is the halt opcode, everything else opcode 1.
    assign imem_data = (imem_addr == 16'h0010) ? 16'hF000 : {4'h1, imem_addr[11:0]};

    fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_data  (imem_data),
        .if_stall   (if_stall),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pcs     (if_pcs),
        .br_valid   (br_valid),
        .br_src     (br_src),
        .br_cond    (br_cond),
        .br_imm_tgt (br_imm_tgt),
        .br_reg_tgt (br_reg_tgt),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_v     (flag_v),
        .flush      (flush),
        .halted     (halted)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},    {15'd0, imem_req}, 16'h0);
        chk({tag, "_addr"},   imem_addr,         16'h0);
        chk({tag, "_valid"},  {15'd0, if_valid}, 16'h0);
        chk({tag, "_instr"},  if_instr,          16'h0);
        chk({tag, "_pc"},     if_pc,             16'h0);
        chk({tag, "_pcs"},    if_pcs,            16'h0);
        chk({tag, "_flush"},  {15'd0, flush},    16'h0);
        chk({tag, "_halted"}, {15'd0, halted},   16'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 3'b111, 1'bx, 1'bx, 1'bx, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; imem_ready = 1'b1; if_stall = 1'b0;
        br_valid = 1'b0; br_src = 1'b0; br_cond = 3'b000;
        br_imm_tgt = 16'h0; br_reg_tgt = 16'h0;
        flag_z = 1'b0; flag_n = 1'b0; flag_v = 1'b0;

        repeat (2) @(posedge clk);
        #3;
        chk_reset_outputs("rst");

        // Zero-wait sequential fetch.
        tick(); rst_n = 1'b1; #2;
        chk("c0_req", {15'd0, imem_req}, 16'h0);
        tick(); #2;
        chk("c1_req", {15'd0, imem_req}, 16'h1);
        chk("c1_addr", imem_addr, 16'h0000);
        chk("c1_valid", {15'd0, if_valid}, 16'h0);
        tick(); #2;
        chk("c2_addr", imem_addr, 16'h0002);
        chk("c2_valid", {15'd0, if_valid}, 16'h1);
        chk("c2_pc", if_pc, 16'h0000);
        chk("c2_pcs", if_pcs, 16'h0002);
        chk("c2_instr", if_instr, 16'h1000);
        chk("c2_flush", {15'd0, flush}, 16'h0);
        tick(); #2;
        chk("c3_addr", imem_addr, 16'h0004);
        chk("c3_pc", if_pc, 16'h0002);

        // Stall three cycles at if_pc=4, then two wait states on address 6.
        tick(); if_stall = 1'b1; imem_ready = 1'b0; #2;
        chk("c4_req", {15'd0, imem_req}, 16'h0);
        chk("c4_addr", imem_addr, 16'h0006);
        chk("c4_pc", if_pc, 16'h0004);
        chk("c4_pcs", if_pcs, 16'h0006);
        chk("c4_instr", if_instr, 16'h1004);
        for (int i = 0; i < 2; i++) begin
            tick(); #2;
            chk("stall_req", {15'd0, imem_req}, 16'h0);
            chk("stall_addr", imem_addr, 16'h0006);
            chk("stall_instr", if_instr, 16'h1004);
            chk("stall_valid", {15'd0, if_valid}, 16'h1);
        end
        tick(); if_stall = 1'b0; #2;
        chk("c7_req", {15'd0, imem_req}, 16'h1);
        chk("c7_addr", imem_addr, 16'h0006);
        chk("c7_valid", {15'd0, if_valid}, 16'h1);
        tick(); #2;
        chk("c8_req", {15'd0, imem_req}, 16'h1);
        chk("c8_addr", imem_addr, 16'h0006);
        chk("c8_valid", {15'd0, if_valid}, 16'h0);
        tick(); imem_ready = 1'b1; #2;
        chk("c9_addr", imem_addr, 16'h0006);

        // Register-target branch while the fetch of 0x0008 waits two cycles.
        tick(); imem_ready = 1'b0;
        br_valid = 1'b1; br_src = 1'b1; br_cond = 3'b111; br_reg_tgt = 16'h0040; br_imm_tgt = 16'h0000;
        #2;
        chk("c10_addr", imem_addr, 16'h0008);
        chk("c10_pc", if_pc, 16'h0006);
        chk("c10_instr", if_instr, 16'h1006);
        chk("c10_flush", {15'd0, flush}, 16'h0);
        tick(); br_valid = 1'b0; br_src = 1'b0; #2;
        chk("drain1_req", {15'd0, imem_req}, 16'h1);
        chk("drain1_addr", imem_addr, 16'h0008);
        chk("drain1_flush", {15'd0, flush}, 16'h1);
        chk("drain1_valid", {15'd0, if_valid}, 16'h0);
        tick(); imem_ready = 1'b1; #2;
        chk("drain2_addr", imem_addr, 16'h0008);
        chk("drain2_flush", {15'd0, flush}, 16'h0);
        tick(); #2;
        chk("post_drain_addr", imem_addr, 16'h0040);
        chk("post_drain_valid", {15'd0, if_valid}, 16'h0);
        tick(); br_valid = 1'b1; br_cond = 3'b111; br_imm_tgt = 16'h000E; #2;
        chk("c14_addr", imem_addr, 16'h0042);
        chk("c14_pc", if_pc, 16'h0040);
        chk("c14_valid", {15'd0, if_valid}, 16'h1);

        // Walk into the halt word at 0x0010.
        tick(); br_valid = 1'b0; #2;
        chk("c15_addr", imem_addr, 16'h000E);
        chk("c15_flush", {15'd0, flush}, 16'h1);
        tick(); #2;
        chk("c16_addr", imem_addr, 16'h0010);
        for (int i = 0; i < 5; i++) begin
            tick(); #2;
            chk("halt_halted", {15'd0, halted}, 16'h1);
            chk("halt_req", {15'd0, imem_req}, 16'h0);
            chk("halt_pc_hold", imem_addr, 16'h0010);
            if (i == 0) begin
                chk("halt_instr", if_instr, 16'hF000);
                chk("halt_if_pc", if_pc, 16'h0010);
                chk("halt_valid", {15'd0, if_valid}, 16'h1);
            end
        end
        tick(); br_valid = 1'b1; br_cond = 3'b111; br_imm_tgt = 16'h0020; #2;
        chk("c22_halted", {15'd0, halted}, 16'h1);
        tick(); br_valid = 1'b0; #2;
        chk("resume_halted", {15'd0, halted}, 16'h0);
        chk("resume_flush", {15'd0, flush}, 16'h1);
        chk("resume_req", {15'd0, imem_req}, 16'h1);
        chk("resume_addr", imem_addr, 16'h0020);

        // Reset asserted in the middle of a drain.
        tick(); imem_ready = 1'b0; br_valid = 1'b1; br_cond = 3'b111; br_imm_tgt = 16'h0060; #2;
        chk("c24_addr", imem_addr, 16'h0022);
        chk("c24_pc", if_pc, 16'h0020);
        chk("c24_flush", {15'd0, flush}, 16'h0);
        tick(); br_valid = 1'b0; #2;
        chk("c25_req", {15'd0, imem_req}, 16'h1);
        chk("c25_addr", imem_addr, 16'h0022);
        chk("c25_flush", {15'd0, flush}, 16'h1);
        rst_n = 1'b0; #1;
        chk_reset_outputs("async_rst");
        tick(); imem_ready = 1'b1;
        tick(); rst_n = 1'b1; #2;
        chk("r0_req", {15'd0, imem_req}, 16'h0);
        tick(); #2;
        chk("r1_req", {15'd0, imem_req}, 16'h1);
        chk("r1_addr", imem_addr, 16'h0000);
        tick(); #2;
        chk("r2_addr", imem_addr, 16'h0002);
        chk("r2_pc", if_pc, 16'h0000);

        // Condition sweep: redirect to 0x0100, then apply the vector.
        for (int i = 0; i < 17; i++) begin
            tick();
            br_valid = 1'b1; br_src = 1'b0; br_cond = 3'b111; br_imm_tgt = 16'h0100;
            flag_z = 1'b0; flag_n = 1'b0; flag_v = 1'b0;
            tick();
            br_valid = vecs[i].v; br_src = vecs[i].src; br_cond = vecs[i].cond;
            flag_z = vecs[i].z; flag_n = vecs[i].n; flag_v = vecs[i].vf;
            br_imm_tgt = vecs[i].src ? 16'h0050 : 16'h0030;
            br_reg_tgt = vecs[i].src ? 16'h0030 : 16'h0070;
            #2;
            chk("vec_base_addr", imem_addr, 16'h0100);
            chk("vec_base_flush", {15'd0, flush}, 16'h1);
            tick();
            br_valid = 1'b0; flag_z = 1'b0; flag_n = 1'b0; flag_v = 1'b0;
            #2;
            chk($sformatf("vec%0d_flush", i), {15'd0, flush}, {15'd0, vecs[i].exp_taken});
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_taken ? 16'h0030 : 16'h0102);
            chk($sformatf("vec%0d_valid", i), {15'd0, if_valid}, {15'd0, ~vecs[i].exp_taken});
            if (!vecs[i].exp_taken) begin
                chk($sformatf("vec%0d_pc", i), if_pc, 16'h0100);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
